region_compositor: RTL and testbench

- Parametrised, pipelined successor to the single-rectangle display comparator.
- Holds N_REGIONS rectangles (paddles, ball, score digits, net) and tests every pixel from the VGA timing generator against all of them.
- Emits a registered priority-resolved hit and per-region hit mask for the colour mux.
- Accumulates per-frame overlap (collision) flags for the game FSM.
- Region bounds are double-buffered so game logic can update positions at any time without tearing.

---
 rtl/region_compositor_if.sv | 42 ++++
 rtl/region_compositor.sv | 128 ++++++++++++
 tb/tb_region_compositor.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/region_compositor_if.sv
`default_nettype none
// ============================================================================
// Module   : region_compositor_if
// Brief    : Pixel, region-config and hit/collision signals of region_compositor.
// Revision : 1.0 - initial release
// ============================================================================
interface region_compositor_if #(
   parameter int N_REGIONS = 4,
   parameter int CW        = 10,
   parameter int IW        = $clog2(N_REGIONS)
);
   logic [CW-1:0]        h_count;
   logic [CW-1:0]        v_count;
   logic                 pix_valid;
   logic                 frame_start;
   logic                 cfg_we;
   logic [IW-1:0]        cfg_idx;
   logic                 cfg_en;
   logic [CW-1:0]        cfg_h_lower;
   logic [CW-1:0]        cfg_h_upper;
   logic [CW-1:0]        cfg_v_lower;
   logic [CW-1:0]        cfg_v_upper;
   logic                 out_valid;
   logic                 hit;
   logic [IW-1:0]        hit_idx;
   logic [N_REGIONS-1:0] hit_mask;
   logic [N_REGIONS-1:0] coll_mask;
   logic                 coll_valid;

   modport master (
      output h_count, v_count, pix_valid, frame_start,
      output cfg_we, cfg_idx, cfg_en, cfg_h_lower, cfg_h_upper, cfg_v_lower, cfg_v_upper,
      input  out_valid, hit, hit_idx, hit_mask, coll_mask, coll_valid
   );

   modport slave (
      input  h_count, v_count, pix_valid, frame_start,
      input  cfg_we, cfg_idx, cfg_en, cfg_h_lower, cfg_h_upper, cfg_v_lower, cfg_v_upper,
      output out_valid, hit, hit_idx, hit_mask, coll_mask, coll_valid
   );
endinterface
`default_nettype wire

// File: rtl/region_compositor.sv
`default_nettype none
// ============================================================================
// Module   : region_compositor
// Brief    : Tests each pixel against N double-buffered rectangles; registered
//            priority hit, hit mask and per-frame overlap flags.
// Revision : 1.0 - initial release
// ============================================================================
module region_compositor #(
   parameter int N_REGIONS = 4,
   parameter int CW        = 10,
   parameter int IW        = $clog2(N_REGIONS)
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   region_compositor_if.slave bus
);

   logic [N_REGIONS-1:0] w_match;
   logic                 w_cfg_ok;
   logic                 w_multi;
   logic [IW-1:0]        w_low_idx;

   logic [N_REGIONS-1:0] r_s1_mask;
   logic                 r_s1_valid;
   logic [N_REGIONS-1:0] r_hit_mask;
   logic                 r_hit;
   logic [IW-1:0]        r_hit_idx;
   logic                 r_out_valid;
   logic [N_REGIONS-1:0] r_coll_acc;
   logic [N_REGIONS-1:0] r_coll_mask;
   logic                 r_coll_valid;

   // Widened compare so out-of-range indices are rejected even when IW is wide.
   assign w_cfg_ok = bus.cfg_we && (32'(bus.cfg_idx) < N_REGIONS);

   for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_region
      logic          r_sh_en, r_act_en;
      logic [CW-1:0] r_sh_hl, r_sh_hu, r_sh_vl, r_sh_vu;
      logic [CW-1:0] r_act_hl, r_act_hu, r_act_vl, r_act_vu;

      // Swap reads the pre-write shadow, so a coincident write waits a frame.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_sh_en  <= 1'b0;
            r_sh_hl  <= '0;
            r_sh_hu  <= '0;
            r_sh_vl  <= '0;
            r_sh_vu  <= '0;
            r_act_en <= 1'b0;
            r_act_hl <= '0;
            r_act_hu <= '0;
            r_act_vl <= '0;
            r_act_vu <= '0;
         end else begin
            if (bus.frame_start) begin
               r_act_en <= r_sh_en;
               r_act_hl <= r_sh_hl;
               r_act_hu <= r_sh_hu;
               r_act_vl <= r_sh_vl;
               r_act_vu <= r_sh_vu;
            end
            if (w_cfg_ok && (32'(bus.cfg_idx) == gi)) begin
               r_sh_en <= bus.cfg_en;
               r_sh_hl <= bus.cfg_h_lower;
               r_sh_hu <= bus.cfg_h_upper;
               r_sh_vl <= bus.cfg_v_lower;
               r_sh_vu <= bus.cfg_v_upper;
            end
         end
      end

      assign w_match[gi] = r_act_en & bus.pix_valid
                         & (bus.h_count >= r_act_hl) & (bus.h_count < r_act_hu)
                         & (bus.v_count >= r_act_vl) & (bus.v_count < r_act_vu);
   end

   // Two or more bits set iff clearing the lowest set bit leaves something.
   assign w_multi = |(r_s1_mask & (r_s1_mask - N_REGIONS'(1)));

   always_comb begin
      w_low_idx = '0;
      for (int i = N_REGIONS - 1; i >= 0; i--) begin
         if (r_s1_mask[i]) begin
            w_low_idx = IW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_mask    <= '0;
         r_s1_valid   <= 1'b0;
         r_hit_mask   <= '0;
         r_hit        <= 1'b0;
         r_hit_idx    <= '0;
         r_out_valid  <= 1'b0;
         r_coll_acc   <= '0;
         r_coll_mask  <= '0;
         r_coll_valid <= 1'b0;
      end else begin
         r_s1_mask   <= w_match;
         r_s1_valid  <= bus.pix_valid;
         r_hit_mask  <= r_s1_mask;
         r_hit       <= |r_s1_mask;
         r_hit_idx   <= w_low_idx;
         r_out_valid <= r_s1_valid;
         if (bus.frame_start) begin
            r_coll_mask  <= r_coll_acc | (w_multi ? r_s1_mask : '0);
            r_coll_acc   <= '0;
            r_coll_valid <= 1'b1;
         end else begin
            r_coll_valid <= 1'b0;
            if (w_multi) begin
               r_coll_acc <= r_coll_acc | r_s1_mask;
            end
         end
      end
   end

   assign bus.out_valid  = r_out_valid;
   assign bus.hit        = r_hit;
   assign bus.hit_idx    = r_hit_idx;
   assign bus.hit_mask   = r_hit_mask;
   assign bus.coll_mask  = r_coll_mask;
   assign bus.coll_valid = r_coll_valid;

endmodule
`default_nettype wire

// File: tb/tb_region_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_region_compositor
// Brief    : Directed bench for region_compositor with a pixel-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_region_compositor;
   localparam int N  = 4;
   localparam int CW = 10;
   // Index width widened to 3 so an out-of-range index such as 5 is expressible.
   localparam int IW = 3;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   bit   chk_en;

   region_compositor_if #(.N_REGIONS(N), .CW(CW), .IW(IW)) bus ();

   region_compositor #(.N_REGIONS(N), .CW(CW), .IW(IW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          en;
      logic [CW-1:0] hl, hu, vl, vu;
   } region_t;

   region_t       m_sh [N];
   region_t       m_act[N];
   logic [N-1:0]  p1_mask, n_mask, acc;
   logic          p1_valid;
   logic [N-1:0]  e_mask, e_cmask;
   logic          e_hit, e_valid, e_cvalid;
   logic [IW-1:0] e_idx;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic logic [N-1:0] hits_at(input logic [CW-1:0] h, input logic [CW-1:0] v);
      logic [N-1:0] m;
      m = '0;
      for (int i = 0; i < N; i++)
         if (m_act[i].en && h >= m_act[i].hl && h < m_act[i].hu && v >= m_act[i].vl && v < m_act[i].vu)
            m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [IW-1:0] first_set(input logic [N-1:0] m);
      for (int i = 0; i < N; i++)
         if (m[i]) return IW'(i);
      return '0;
   endfunction

   // Reference model: inputs sampled on the edge, expectations checked 1 time unit later.
   initial begin : model
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
               m_sh[i]  = '0;
               m_act[i] = '0;
            end
            p1_mask = '0; p1_valid = 1'b0; acc = '0;
            e_mask = '0; e_hit = 1'b0; e_idx = '0; e_valid = 1'b0;
            e_cmask = '0; e_cvalid = 1'b0;
         end else begin
            n_mask  = bus.pix_valid ? hits_at(bus.h_count, bus.v_count) : '0;
            e_mask  = p1_mask;
            e_hit   = (p1_mask != '0);
            e_idx   = first_set(p1_mask);
            e_valid = p1_valid;
            if (bus.frame_start) begin
               e_cmask  = acc | (($countones(p1_mask) >= 2) ? p1_mask : '0);
               acc      = '0;
               e_cvalid = 1'b1;
            end else begin
               e_cvalid = 1'b0;
               if ($countones(p1_mask) >= 2) acc = acc | p1_mask;
            end
            p1_mask  = n_mask;
            p1_valid = bus.pix_valid;
            if (bus.frame_start)
               for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
            if (bus.cfg_we && bus.cfg_idx < 3'd4)
               m_sh[bus.cfg_idx[1:0]] = {bus.cfg_en, bus.cfg_h_lower, bus.cfg_h_upper,
                                         bus.cfg_v_lower, bus.cfg_v_upper};
         end
         #1;
         if (chk_en) begin
            chk("m_out_valid",  32'(bus.out_valid),  32'(e_valid));
            chk("m_hit",        32'(bus.hit),        32'(e_hit));
            chk("m_hit_idx",    32'(bus.hit_idx),    32'(e_idx));
            chk("m_hit_mask",   32'(bus.hit_mask),   32'(e_mask));
            chk("m_coll_mask",  32'(bus.coll_mask),  32'(e_cmask));
            chk("m_coll_valid", 32'(bus.coll_valid), 32'(e_cvalid));
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.h_count = '0; bus.v_count = '0; bus.pix_valid = 1'b0; bus.frame_start = 1'b0;
      bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_en = 1'b0;
      bus.cfg_h_lower = '0; bus.cfg_h_upper = '0; bus.cfg_v_lower = '0; bus.cfg_v_upper = '0;
   endtask

   task automatic random_inputs();
      bus.h_count = CW'($urandom); bus.v_count = CW'($urandom);
      bus.pix_valid = 1'($urandom); bus.frame_start = 1'($urandom);
      bus.cfg_we = 1'($urandom); bus.cfg_idx = IW'($urandom); bus.cfg_en = 1'($urandom);
      bus.cfg_h_lower = CW'($urandom); bus.cfg_h_upper = CW'($urandom);
      bus.cfg_v_lower = CW'($urandom); bus.cfg_v_upper = CW'($urandom);
   endtask

   task automatic set_cfg(input int idx, input bit en, input int hl, input int hu, input int vl, input int vu);
      bus.cfg_idx = IW'(idx); bus.cfg_en = en;
      bus.cfg_h_lower = CW'(hl); bus.cfg_h_upper = CW'(hu);
      bus.cfg_v_lower = CW'(vl); bus.cfg_v_upper = CW'(vu);
   endtask

   task automatic write_cfg(input int idx, input bit en, input int hl, input int hu, input int vl, input int vu);
      set_cfg(idx, en, hl, hu, vl, vu);
      bus.cfg_we = 1'b1;
      cyc();
      bus.cfg_we = 1'b0;
   endtask

   task automatic pulse_fs();
      bus.frame_start = 1'b1;
      cyc();
      bus.frame_start = 1'b0;
   endtask

   task automatic set_px(input int h, input int v);
      bus.pix_valid = 1'b1; bus.h_count = CW'(h); bus.v_count = CW'(v);
   endtask

   // One isolated pixel, then its registered result two edges later.
   task automatic expect_px(input string name, input int h, input int v,
                            input logic [N-1:0] mask, input int idx);
      set_px(h, v);
      cyc();
      bus.pix_valid = 1'b0;
      cyc();
      chk({name, "_mask"}, 32'(bus.hit_mask),  32'(mask));
      chk({name, "_hit"},  32'(bus.hit),       32'(mask != '0));
      chk({name, "_idx"},  32'(bus.hit_idx),   32'(idx));
      chk({name, "_ov"},   32'(bus.out_valid), 32'd1);
   endtask

   initial begin : stim
      n_checks = 0; n_fail = 0; chk_en = 1'b0;
      rst_n = 1'b0;
      random_inputs();
      cyc();
      chk_en = 1'b1;
      random_inputs();
      cyc();
      chk("rst_hit",        32'(bus.hit),        32'd0);
      chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
      chk("rst_hit_mask",   32'(bus.hit_mask),   32'd0);
      chk("rst_coll_mask",  32'(bus.coll_mask),  32'd0);
      chk("rst_coll_valid", 32'(bus.coll_valid), 32'd0);
      rst_n = 1'b1;
      idle_inputs();
      cyc();

      // No configuration: valid pixel produces no hit.
      pulse_fs();
      expect_px("idle", 100, 100, 4'b0000, 0);

      // Single region boundaries: h in [10,20), v in [5,8).
      write_cfg(1, 1'b1, 10, 20, 5, 8);
      pulse_fs();
      expect_px("b_9_5",   9, 5, 4'b0000, 0);
      expect_px("b_10_5", 10, 5, 4'b0010, 1);
      expect_px("b_19_5", 19, 5, 4'b0010, 1);
      expect_px("b_20_5", 20, 5, 4'b0000, 0);
      expect_px("b_10_8", 10, 8, 4'b0000, 0);
      expect_px("b_19_8", 19, 8, 4'b0000, 0);

      // Priority and collision.
      write_cfg(0, 1'b1, 0, 50, 0, 50);
      write_cfg(2, 1'b1, 40, 60, 40, 60);
      pulse_fs();
      expect_px("prio", 45, 45, 4'b0101, 0);
      pulse_fs();
      chk("coll_mask_1",  32'(bus.coll_mask),  32'h5);
      chk("coll_valid_1", 32'(bus.coll_valid), 32'd1);
      cyc();
      chk("coll_valid_0", 32'(bus.coll_valid), 32'd0);
      expect_px("solo", 10, 10, 4'b0001, 0);
      pulse_fs();
      chk("coll_mask_clr", 32'(bus.coll_mask), 32'h0);
      // Overlapping pixel still in stage 1 when frame_start lands.
      set_px(45, 45);
      cyc();
      bus.pix_valid = 1'b0;
      pulse_fs();
      chk("coll_inflight", 32'(bus.coll_mask), 32'h5);
      // Back-to-back burst across the overlap.
      for (int h = 36; h < 64; h++) begin
         set_px(h, 45);
         cyc();
      end
      bus.pix_valid = 1'b0;
      cyc(); cyc();
      pulse_fs();
      chk("coll_burst", 32'(bus.coll_mask), 32'h5);
      pulse_fs();
      chk("coll_none", 32'(bus.coll_mask), 32'h0);

      // Double buffering: mid-frame write waits for frame_start.
      write_cfg(0, 1'b1, 100, 120, 100, 120);
      expect_px("db_old",    10,  10, 4'b0001, 0);
      expect_px("db_newno", 110, 110, 4'b0000, 0);
      pulse_fs();
      expect_px("db_new",   110, 110, 4'b0001, 0);
      expect_px("db_oldno",  10,  10, 4'b0000, 0);
      // Write coincident with frame_start lands one frame later.
      set_cfg(0, 1'b1, 200, 220, 200, 220);
      bus.cfg_we = 1'b1;
      pulse_fs();
      bus.cfg_we = 1'b0;
      expect_px("co_keep",  110, 110, 4'b0001, 0);
      expect_px("co_notyet",210, 210, 4'b0000, 0);
      pulse_fs();
      expect_px("co_apply", 210, 210, 4'b0001, 0);

      // Illegal index, degenerate and disabled regions.
      write_cfg(5, 1'b1, 0, 1000, 0, 1000);
      pulse_fs();
      expect_px("illegal", 500, 500, 4'b0000, 0);
      write_cfg(3, 1'b1, 30, 30, 0, 100);
      write_cfg(1, 1'b0, 0, 100, 0, 100);
      pulse_fs();
      expect_px("degen",   30, 50, 4'b0000, 0);
      expect_px("disab",   50, 50, 4'b0100, 2);

      // Reset mid-frame with a hit in flight.
      set_px(50, 50);
      cyc();
      rst_n = 1'b0;
      cyc();
      chk("mrst_hit",       32'(bus.hit),       32'd0);
      chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
      rst_n = 1'b1;
      bus.pix_valid = 1'b0;
      cyc();
      pulse_fs();
      expect_px("post_rst", 50, 50, 4'b0000, 0);

      cyc(); cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
